// File: rtl/req_gnt_pkg.sv
// req_gnt_pkg
// Shared definitions for the request/grant port: handshake state encoding,
// state width and default parameter values.
package req_gnt_pkg;

  localparam int STATE_W     = 2;
  localparam int CNT_W_DEF   = 8;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at MAX instead of wrapping. Clear wins over increment.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   clr_i       synchronous clear to zero
//   inc_i       count up by one (ignored once at MAX)
//   cnt_o       current count
module sat_counter #(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/req_gnt_port.sv
// req_gnt_port
// Request/grant port for a single requester. Drives a registered request,
// samples the returning grant, tracks the handshake and reports grants,
// wait timeouts and a saturating grant count. All outputs are registered.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   drv_valid_i    load drv_req_i into req at the next edge (beats tgl_i)
//   drv_req_i      value to load
//   tgl_i          invert req at the next edge
//   clr_cnt_i      clear grant count (beats a coincident grant)
//   gnt_i          grant from the responder
//   req_o          registered request
//   gnt_q_o        gnt_i sampled at the last edge
//   state_o        IDLE=0, WAIT=1, GRANT=2
//   granted_o      one-cycle pulse on entry to GRANT
//   timeout_o      one-cycle pulse when a WAIT episode reaches TIMEOUT cycles
//   grant_cnt_o    saturating grant count
//
// state | meaning
// IDLE  | no request outstanding
// WAIT  | request high, grant not yet seen
// GRANT | request high and grant sampled high
module req_gnt_port
  import req_gnt_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               drv_valid_i,
  input  logic               drv_req_i,
  input  logic               tgl_i,
  input  logic               clr_cnt_i,
  input  logic               gnt_i,
  output logic               req_o,
  output logic               gnt_q_o,
  output logic [STATE_W-1:0] state_o,
  output logic               granted_o,
  output logic               timeout_o,
  output logic [CNT_W-1:0]   grant_cnt_o
);

  // Wait counter only has to reach TIMEOUT-1.
  localparam int                WAIT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_PRE = WAIT_W'(TIMEOUT - 2);

  logic              req_q,     req_d;
  logic              gnt_q;
  state_e            state_q,   state_d;
  logic              granted_q, granted_d;
  logic              timeout_q, timeout_d;
  logic              wait_stay;
  logic [WAIT_W-1:0] wait_cnt;

  always_comb begin
    req_d     = req_q;
    state_d   = IDLE;
    granted_d = 1'b0;
    timeout_d = 1'b0;
    wait_stay = 1'b0;

    if (drv_valid_i) begin
      req_d = drv_req_i;
    end else if (tgl_i) begin
      req_d = ~req_q;
    end

    if (req_q) begin
      state_d = gnt_q ? GRANT : WAIT;
    end

    granted_d = (state_d == GRANT) && (state_q != GRANT);

    // Counter is cleared on any edge that does not keep us in WAIT, so it
    // reads 0 right after entry; the pulse fires on the step to TIMEOUT-1
    // and cannot repeat because the counter then sticks at WAIT_MAX.
    wait_stay = (state_q == WAIT) && (state_d == WAIT);
    timeout_d = wait_stay && (wait_cnt == WAIT_PRE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= 1'b0;
      gnt_q     <= 1'b0;
      state_q   <= IDLE;
      granted_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      req_q     <= req_d;
      gnt_q     <= gnt_i;
      state_q   <= state_d;
      granted_q <= granted_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(
    .W   (WAIT_W),
    .MAX (WAIT_MAX)
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (!wait_stay),
    .inc_i (wait_stay),
    .cnt_o (wait_cnt)
  );

  // Counts on the same edge that raises granted, so the count and the pulse
  // are visible together.
  sat_counter #(
    .W (CNT_W)
  ) u_grant_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr_cnt_i),
    .inc_i (granted_d),
    .cnt_o (grant_cnt_o)
  );

  assign req_o     = req_q;
  assign gnt_q_o   = gnt_q;
  assign state_o   = state_q;
  assign granted_o = granted_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_req_gnt_port.sv
module tb_req_gnt_port;

  localparam int CNT_W   = 2;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic drv_valid = 1'b0;
  logic drv_req = 1'b0;
  logic tgl = 1'b0;
  logic clr_cnt = 1'b0;
  logic gnt = 1'b0;
  logic req, gnt_q, granted, timeout;
  logic [1:0] state;
  logic [CNT_W-1:0] grant_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model: state as 0/1/2 from the handshake rules, WAIT episode age
  // as a plain unbounded cycle count.
  int m_req, m_gq, m_state, m_granted, m_timeout, m_cnt, m_age;
  int echo = 0;

  always #5 clk = ~clk;

  req_gnt_port #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .drv_valid_i (drv_valid),
    .drv_req_i   (drv_req),
    .tgl_i       (tgl),
    .clr_cnt_i   (clr_cnt),
    .gnt_i       (gnt),
    .req_o       (req),
    .gnt_q_o     (gnt_q),
    .state_o     (state),
    .granted_o   (granted),
    .timeout_o   (timeout),
    .grant_cnt_o (grant_cnt)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_gq = 0; m_state = 0; m_granted = 0;
    m_timeout = 0; m_cnt = 0; m_age = 0;
  endtask

  task automatic check_all();
    chk("req", int'(req), m_req);
    chk("gnt_q", int'(gnt_q), m_gq);
    chk("state", int'(state), m_state);
    chk("granted", int'(granted), m_granted);
    chk("timeout", int'(timeout), m_timeout);
    chk("grant_cnt", int'(grant_cnt), m_cnt);
  endtask

  // One clock edge: advance model with the inputs present before the edge,
  // compare, then let the registered responder (gnt <= req) react.
  task automatic tick();
    int o_req, o_gq, o_state, n_state;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      o_req = m_req; o_gq = m_gq; o_state = m_state;
      m_req = drv_valid ? int'(drv_req) : (tgl ? 1 - o_req : o_req);
      m_gq  = int'(gnt);
      n_state = (o_req == 0) ? 0 : ((o_gq != 0) ? 2 : 1);
      m_granted = (n_state == 2 && o_state != 2) ? 1 : 0;
      if (n_state == 1) m_age = (o_state == 1) ? m_age + 1 : 0;
      else m_age = 0;
      m_timeout = (n_state == 1 && o_state == 1 && m_age == TIMEOUT - 1) ? 1 : 0;
      if (clr_cnt) m_cnt = 0;
      else if (m_granted != 0 && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
      m_state = n_state;
      if (echo != 0) gnt = (o_req != 0);
    end
    check_all();
  endtask

  task automatic drive_req(input logic v);
    drv_valid = 1'b1; drv_req = v;
    tick();
    drv_valid = 1'b0; drv_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r[11];
    int nt, seen;
    model_reset();

    // Reset held with gnt and tgl high.
    rst_n = 1'b0; gnt = 1'b1; tgl = 1'b1; echo = 0;
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_release_req", int'(req), 1);

    // Toggle train against the registered responder.
    echo = 1;
    r[0] = 1;
    for (int i = 1; i <= 10; i++) begin
      r[i] = 1 - r[i-1];
      tick();
      chk("tgl_train_req", int'(req), r[i]);
      if (i >= 2) chk("tgl_train_gnt_q", int'(gnt_q), r[i-2]);
    end
    tgl = 1'b0;

    // Settle to idle and clear the count.
    drive_req(1'b0);
    repeat (4) tick();
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    tick();

    // Single grant: granted exactly at N+3.
    drive_req(1'b1);
    tick();
    chk("grant_n1_state", int'(state), 1);
    tick();
    chk("grant_n2_granted", int'(granted), 0);
    tick();
    chk("grant_n3_granted", int'(granted), 1);
    chk("grant_n3_state", int'(state), 2);
    chk("grant_n3_cnt", int'(grant_cnt), 1);
    tick();
    chk("grant_n4_granted", int'(granted), 0);

    // Timeout: gnt held low.
    drive_req(1'b0);
    echo = 0; gnt = 1'b0;
    repeat (3) tick();
    drive_req(1'b1);
    tick();
    chk("to_wait_state", int'(state), 1);
    nt = 0;
    for (int k = 2; k <= 12; k++) begin
      tick();
      if (timeout) nt++;
      if (k == 4) chk("to_pulse_at_n4", int'(timeout), 1);
    end
    chk("to_once", nt, 1);
    chk("to_still_wait", int'(state), 1);
    gnt = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (granted) seen++;
    end
    chk("grant_after_to", seen, 1);

    // drv_valid beats tgl.
    drv_valid = 1'b1; drv_req = 1'b0; tgl = 1'b1;
    tick();
    chk("priority_req", int'(req), 0);
    drv_valid = 1'b0; tgl = 1'b0;

    // Saturation with CNT_W=2.
    echo = 1;
    repeat (3) tick();
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    for (int g = 0; g < 5; g++) begin
      drive_req(1'b1);
      repeat (3) tick();
      drive_req(1'b0);
      repeat (3) tick();
    end
    chk("sat_cnt", int'(grant_cnt), 3);

    // Clear coincident with a grant: the grant is lost.
    repeat (2) tick();
    drive_req(1'b1);
    tick();
    tick();
    clr_cnt = 1'b1;
    tick();
    chk("clr_grant_granted", int'(granted), 1);
    chk("clr_grant_cnt", int'(grant_cnt), 0);
    clr_cnt = 1'b0;
    tick();
    chk("mid_pre_state", int'(state), 2);

    // Asynchronous reset in GRANT.
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_reset_req", int'(req), 0);
    chk("post_reset_state", int'(state), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) echo = int'($urandom_range(0, 1));
      drv_valid = ($urandom_range(0, 7) == 0);
      drv_req   = 1'($urandom_range(0, 1));
      tgl       = ($urandom_range(0, 3) == 0);
      clr_cnt   = ($urandom_range(0, 31) == 0);
      if (echo == 0) gnt = ($urandom_range(0, 3) != 0);
      tick();
    end
    drv_valid = 1'b0; tgl = 1'b0; clr_cnt = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
